// File: rtl/axis_rs232_arbiter_if.sv
// Handshake bundle between CHANNELS AXI-stream byte sources, the arbiter and the
// downstream RS-232 transmitter.
interface axis_rs232_arbiter_if #(
    parameter int unsigned CHANNELS = 4
);
    logic [8*CHANNELS-1:0] idata;
    logic [CHANNELS-1:0]   ivalid;
    logic [CHANNELS-1:0]   ilast;
    logic [CHANNELS-1:0]   iready;
    logic [7:0]            odata;
    logic                  ovalid;
    logic                  oready;
    logic [CHANNELS-1:0]   grant;
    logic                  busy;

    // Arbiter side.
    modport master (
        input  idata, ivalid, ilast, oready,
        output iready, odata, ovalid, grant, busy
    );

    // Sources plus transmitter side.
    modport slave (
        output idata, ivalid, ilast, oready,
        input  iready, odata, ovalid, grant, busy
    );
endinterface

// File: rtl/axis_rs232_arbiter.sv
// Packet-granular round-robin arbiter sharing one axis_to_rs232 transmitter among
// CHANNELS byte streams. Optional channel header byte: AXIS_RS232_ARBITER_TAG_EN.
module axis_rs232_arbiter #(
    parameter int unsigned CHANNELS   = 4,
    parameter int unsigned MAX_PACKET = 256
) (
    input logic                  clock,
    input logic                  reset,
    axis_rs232_arbiter_if.master bus
);
    localparam int unsigned SelW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

`ifdef AXIS_RS232_ARBITER_TAG_EN
    typedef enum logic [1:0] {StIdle, StTag, StPass} state_e;
`else
    typedef enum logic [0:0] {StIdle, StPass} state_e;
`endif

    state_e              state_q;
    logic [SelW-1:0]     sel_q;
    logic [SelW-1:0]     last_owner_q;
    logic [CHANNELS-1:0] grant_q;
    logic [15:0]         cnt_q;

    logic [SelW-1:0]     pick;
    logic [SelW-1:0]     idx;
    int unsigned         idx_wide;
    logic                found;
    logic                xfer;
    logic                release_pkt;
    logic [7:0]          odata;
    logic                ovalid;
    logic [CHANNELS-1:0] iready;

    // First requester after last_owner, wrapping; last_owner itself is scanned last.
    always_comb begin
        pick     = last_owner_q;
        found    = 1'b0;
        idx      = '0;
        idx_wide = 0;
        for (int unsigned i = 1; i <= CHANNELS; i++) begin
            idx_wide = 32'(last_owner_q) + i;
            if (idx_wide >= CHANNELS) idx_wide = idx_wide - CHANNELS;
            idx = idx_wide[SelW-1:0];
            if (!found && bus.ivalid[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        odata  = '0;
        ovalid = 1'b0;
        iready = '0;
        case (state_q)
            StPass: begin
                odata         = bus.idata[{sel_q, 3'b000} +: 8];
                ovalid        = bus.ivalid[sel_q];
                iready[sel_q] = bus.oready;
            end
`ifdef AXIS_RS232_ARBITER_TAG_EN
            StTag: begin
                odata  = {4'hA, 4'(sel_q)};
                ovalid = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign xfer        = (state_q == StPass) && bus.ivalid[sel_q] && bus.oready;
    assign release_pkt = xfer && (bus.ilast[sel_q] || (32'(cnt_q) == MAX_PACKET - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            sel_q        <= '0;
            last_owner_q <= SelW'(CHANNELS - 1);
            grant_q      <= '0;
            cnt_q        <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (found) begin
                        sel_q   <= pick;
                        grant_q <= {{(CHANNELS-1){1'b0}}, 1'b1} << pick;
`ifdef AXIS_RS232_ARBITER_TAG_EN
                        state_q <= StTag;
`else
                        state_q <= StPass;
`endif
                    end
                end
`ifdef AXIS_RS232_ARBITER_TAG_EN
                StTag: begin
                    if (bus.oready) state_q <= StPass;
                end
`endif
                StPass: begin
                    if (release_pkt) begin
                        last_owner_q <= sel_q;
                        cnt_q        <= '0;
                        grant_q      <= '0;
                        state_q      <= StIdle;
                    end else if (xfer) begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.odata  = odata;
    assign bus.ovalid = ovalid;
    assign bus.iready = iready;
    assign bus.grant  = grant_q;
    assign bus.busy   = (state_q != StIdle);
endmodule

// File: tb/tb_axis_rs232_arbiter.sv
// Bench for axis_rs232_arbiter: per-channel byte queues feed the DUT, a packet-level
// owner model predicts every output each cycle, and directed scenarios pin literal results.
module tb_axis_rs232_arbiter;
    localparam int unsigned CH    = 4;
    localparam int unsigned MAXP  = 256;
    localparam int          DEPTH = 8192;
`ifdef AXIS_RS232_ARBITER_TAG_EN
    localparam bit TagEn = 1'b1;
`else
    localparam bit TagEn = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset;

    axis_rs232_arbiter_if #(.CHANNELS(CH)) bus ();

    axis_rs232_arbiter #(
        .CHANNELS  (CH),
        .MAX_PACKET(MAXP)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    logic [8:0] src_mem [CH][DEPTH];
    int         head [CH];
    int         tail [CH];
    bit         en [CH];
    bit         ordy;

    // Model: who owns the transmitter, whether its header is still pending, bytes sent.
    int m_owner;
    int m_last;
    int m_cnt;
    bit m_tag;
    bit checking;

    logic [7:0] out_q[$];
    logic [7:0] all_q[$];
    logic [7:0] exp_q[$];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_seq(string name);
        chk({name, "_len"}, 32'(out_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++)
            chk(name, {24'd0, out_q[i]}, {24'd0, exp_q[i]});
    endtask

    task automatic push(int k, logic [7:0] d, bit last);
        if (tail[k] < DEPTH) begin
            src_mem[k][tail[k]] = {last, d};
            tail[k]++;
        end
    endtask

    function automatic bit pending();
        bit p = (m_owner >= 0);
        for (int k = 0; k < CH; k++) if (head[k] < tail[k]) p = 1'b1;
        return p;
    endfunction

    task automatic drive();
        for (int k = 0; k < CH; k++) begin
            bit v;
            v = (head[k] < tail[k]) && en[k];
            bus.ivalid[k]        = v;
            bus.idata[8*k +: 8]  = v ? src_mem[k][head[k]][7:0] : 8'($urandom);
            bus.ilast[k]         = v ? src_mem[k][head[k]][8] : 1'($urandom);
        end
        bus.oready = ordy;
    endtask

    task automatic compare();
        logic [CH-1:0] e_grant;
        logic [CH-1:0] e_iready;
        logic [7:0]    e_odata;
        bit            e_ovalid;
        bit            e_busy;
        e_grant  = '0;
        e_iready = '0;
        e_odata  = '0;
        e_ovalid = 1'b0;
        e_busy   = 1'b0;
        if (m_owner >= 0) begin
            e_busy           = 1'b1;
            e_grant[m_owner] = 1'b1;
            if (m_tag) begin
                e_ovalid = 1'b1;
                e_odata  = 8'hA0 | 8'(m_owner);
            end else begin
                e_ovalid          = bus.ivalid[m_owner];
                e_odata           = bus.idata[8*m_owner +: 8];
                e_iready[m_owner] = bus.oready;
            end
        end
        chk("grant", 32'(bus.grant), 32'(e_grant));
        chk("busy", 32'(bus.busy), 32'(e_busy));
        chk("ovalid", 32'(bus.ovalid), 32'(e_ovalid));
        chk("odata", 32'(bus.odata), 32'(e_odata));
        chk("iready", 32'(bus.iready), 32'(e_iready));
    endtask

    task automatic update();
        if (bus.ovalid === 1'b1 && ordy) begin
            all_q.push_back(bus.odata);
            if (!(m_owner >= 0 && m_tag)) out_q.push_back(bus.odata);
        end
        if (m_owner < 0) begin
            for (int j = 1; j <= CH; j++) begin
                int c;
                c = (m_last + j) % CH;
                if (m_owner < 0 && bus.ivalid[c]) begin
                    m_owner = c;
                    m_tag   = TagEn;
                end
            end
        end else if (m_tag) begin
            if (ordy) m_tag = 1'b0;
        end else if (bus.ivalid[m_owner] && ordy) begin
            bit last;
            last = src_mem[m_owner][head[m_owner]][8];
            head[m_owner]++;
            m_cnt++;
            if (last || m_cnt == MAXP) begin
                m_last  = m_owner;
                m_owner = -1;
                m_cnt   = 0;
            end
        end
        if (reset) begin
            m_owner  = -1;
            m_tag    = 1'b0;
            m_cnt    = 0;
            m_last   = CH - 1;
            checking = 1'b1;
        end
    endtask

    task automatic cycle();
        drive();
        #1;
        if (checking) compare();
        update();
        @(negedge clock);
    endtask

    task automatic run_idle(int maxc, string name);
        int n = 0;
        while (pending() && n < maxc) begin
            cycle();
            n++;
        end
        checks++;
        if (n >= maxc) begin
            errors++;
            $display("FAIL %s_timeout: got %0d cycles required under %0d", name, n, maxc);
        end
        cycle();
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got no finish required finish before 5ms");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        ordy     = 1'b1;
        m_owner  = -1;
        m_last   = CH - 1;
        m_cnt    = 0;
        m_tag    = 1'b0;
        checking = 1'b0;
        for (int k = 0; k < CH; k++) begin
            head[k] = 0;
            tail[k] = 0;
            en[k]   = 1'b1;
        end
        @(negedge clock);
        cycle();
        cycle();
        reset = 1'b0;
        chk("rst_grant", 32'(bus.grant), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_ovalid", 32'(bus.ovalid), 32'd0);
        chk("rst_odata", 32'(bus.odata), 32'd0);

        // Single packet on ch0.
        out_q.delete();
        push(0, 8'h11, 1'b0);
        push(0, 8'h22, 1'b0);
        push(0, 8'h33, 1'b1);
        cycle();
        chk("t1_grant_on", 32'(bus.grant), 32'b0001);
        if (TagEn) cycle();
        cycle();
        cycle();
        cycle();
        chk("t1_grant_off", 32'(bus.grant), 32'd0);
        exp_q = {8'h11, 8'h22, 8'h33};
        chk_seq("t1_bytes");

        // Make ch1 the last owner, then ch1 and ch3 request together.
        push(1, 8'h50, 1'b1);
        run_idle(50, "t2a");
        out_q.delete();
        push(1, 8'h51, 1'b0);
        push(1, 8'h52, 1'b1);
        push(3, 8'h71, 1'b0);
        push(3, 8'h72, 1'b0);
        push(3, 8'h73, 1'b1);
        run_idle(100, "t2");
        exp_q = {8'h71, 8'h72, 8'h73, 8'h51, 8'h52};
        chk_seq("t2_order");

        // ch2 exceeds MAX_PACKET while ch0 waits.
        out_q.delete();
        for (int i = 0; i < 300; i++) push(2, 8'(i), i == 299);
        push(0, 8'hC1, 1'b0);
        push(0, 8'hC2, 1'b1);
        run_idle(1000, "t3");
        chk("t3_len", 32'(out_q.size()), 32'd302);
        chk("t3_b255", 32'(out_q[255]), 32'hFF);
        chk("t3_b256", 32'(out_q[256]), 32'hC1);
        chk("t3_b257", 32'(out_q[257]), 32'hC2);
        chk("t3_b258", 32'(out_q[258]), 32'h00);
        chk("t3_b301", 32'(out_q[301]), 32'h2B);

        // Backpressure and owner stalls, with a non-owner requesting meanwhile.
        out_q.delete();
        for (int i = 0; i < 6; i++) push(1, 8'h31 + 8'(i), i == 5);
        for (int i = 0; i < 24; i++) begin
            if (i == 1) push(0, 8'h0E, 1'b1);
            ordy  = (i % 3) != 1;
            en[1] = !(i >= 4 && i < 9);
            cycle();
        end
        en[1] = 1'b1;
        ordy  = 1'b1;
        run_idle(100, "t4");
        exp_q = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h0E};
        chk_seq("t4_bytes");

        // Reset during byte 2 of 4; partial packet dropped at the source too.
        push(3, 8'h91, 1'b0);
        push(3, 8'h92, 1'b0);
        push(3, 8'h93, 1'b0);
        push(3, 8'h94, 1'b1);
        cycle();
        if (TagEn) cycle();
        cycle();
        reset = 1'b1;
        ordy  = 1'b0;
        cycle();
        reset   = 1'b0;
        ordy    = 1'b1;
        head[3] = tail[3];
        chk("t5_grant", 32'(bus.grant), 32'd0);
        chk("t5_ovalid", 32'(bus.ovalid), 32'd0);
        chk("t5_busy", 32'(bus.busy), 32'd0);
        out_q.delete();
        push(3, 8'hA3, 1'b1);
        push(0, 8'hA0, 1'b1);
        run_idle(100, "t5");
        exp_q = {8'hA0, 8'hA3};
        chk_seq("t5_order");

        // Header byte presence on the wire.
        all_q.delete();
        push(1, 8'hAB, 1'b1);
        run_idle(50, "t6");
        out_q = all_q;
`ifdef AXIS_RS232_ARBITER_TAG_EN
        exp_q = {8'hA1, 8'hAB};
`else
        exp_q = {8'hAB};
`endif
        chk_seq("t6_wire");

        // Random traffic with stalls, backpressure and occasional resets.
        for (int c = 0; c < 4000; c++) begin
            for (int k = 0; k < CH; k++) begin
                if ($urandom_range(15) == 0 && tail[k] < DEPTH - 40) begin
                    int len;
                    len = int'($urandom_range(24, 1));
                    for (int b = 0; b < len; b++) push(k, 8'($urandom), b == len - 1);
                end
                en[k] = $urandom_range(7) != 0;
            end
            ordy  = $urandom_range(3) != 0;
            reset = $urandom_range(699) == 0;
            cycle();
        end
        reset = 1'b0;
        ordy  = 1'b1;
        for (int k = 0; k < CH; k++) en[k] = 1'b1;
        run_idle(20000, "rand_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
